// File: rtl/encoder_rate_meter_pkg.sv
// Shared state encoding, default widths and saturation limits for the
// encoder rate meter.
package encoder_rate_meter_pkg;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  localparam int CW_DEFAULT = 8;
  localparam int RW_DEFAULT = 16;

  function automatic longint satMax(input int rw);
    return (longint'(1) <<< (rw - 1)) - 1;
  endfunction

  function automatic longint satMin(input int rw);
    return -(longint'(1) <<< (rw - 1));
  endfunction

endpackage

// File: rtl/encoder_rate_meter_rate_sat_acc.sv
// Signed window accumulator; presents the saturated value of acc+delta so the
// top level can capture the result on the same cycle the last delta arrives.
module encoder_rate_meter_rate_sat_acc
  import encoder_rate_meter_pkg::*;
#(
  parameter int CW = CW_DEFAULT,
  parameter int RW = RW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          add,
  input  logic [CW-1:0] delta,
  output logic [RW-1:0] satSum
);

  localparam logic [RW-1:0] MAXV = RW'(satMax(RW));
  localparam logic [RW-1:0] MINV = RW'(satMin(RW));

  logic [RW:0] acc;
  logic [RW:0] sum;

  assign sum = acc + {{(RW + 1 - CW){delta[CW-1]}}, delta};

  // One guard bit above RW: the top two bits differing means the sum left the RW range.
  always_comb begin
    satSum = sum[RW-1:0];
    if (sum[RW] != sum[RW-1]) begin
      satSum = sum[RW] ? MINV : MAXV;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/encoder_rate_meter.sv
// Gated rate meter: every GATE_CYCLES clocks reports the signed net change of
// an 8-bit wrapping pulse count, held under a valid/ack handshake.
module encoder_rate_meter
  import encoder_rate_meter_pkg::*;
#(
  parameter int CW          = CW_DEFAULT,
  parameter int RW          = RW_DEFAULT,
  parameter int GATE_CYCLES = 10000
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          En,
  input  logic          Clear,
  input  logic [CW-1:0] Count,
  output logic [RW-1:0] Rate,
  output logic          Rate_Valid,
  input  logic          Rate_Ack,
  output logic          Overrun
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  state_t        state;
  logic [GW-1:0] gate;
  logic [CW-1:0] prev;
  logic [CW-1:0] delta;
  logic [RW-1:0] satSum;
  logic          accAdd;
  logic          accClr;
  logic          windowEnd;

  // Modular difference turns counter wrap-around into a small signed step.
  assign delta     = Count - prev;
  assign accAdd    = (state == RUN) && En;
  assign windowEnd = accAdd && (gate == GATE_LAST);
  assign accClr    = Clear || !accAdd || windowEnd;

  encoder_rate_meter_rate_sat_acc #(
    .CW(CW),
    .RW(RW)
  ) u_acc (
    .clk   (CLK),
    .rst   (RST),
    .clr   (accClr),
    .add   (accAdd),
    .delta (delta),
    .satSum(satSum)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      gate       <= '0;
      prev       <= '0;
      Rate       <= '0;
      Rate_Valid <= 1'b0;
      Overrun    <= 1'b0;
    end else if (Clear) begin
      state      <= En ? PRIME : IDLE;
      gate       <= '0;
      Rate       <= '0;
      Rate_Valid <= 1'b0;
      Overrun    <= 1'b0;
    end else begin
      if (Rate_Valid && Rate_Ack) begin
        Rate_Valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          gate <= '0;
          if (En) begin
            state <= PRIME;
          end
        end
        PRIME: begin
          prev  <= Count;
          gate  <= '0;
          state <= RUN;
        end
        RUN: begin
          if (!En) begin
            gate  <= '0;
            state <= IDLE;
          end else begin
            prev <= Count;
            // A new result always wins over a same-cycle ack of the old one.
            if (windowEnd) begin
              gate       <= '0;
              Rate       <= satSum;
              Rate_Valid <= 1'b1;
              if (Rate_Valid && !Rate_Ack) begin
                Overrun <= 1'b1;
              end
            end else begin
              gate <= gate + GW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_rate_meter.sv
// Self-checking bench: two meters (RW=16 and RW=8) share one stimulus stream
// and are compared each clock against a window-sum reference model.
module tb_encoder_rate_meter;

  localparam int GATE = 100;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        En = 1'b0;
  logic        Clear = 1'b0;
  logic        Rate_Ack = 1'b0;
  logic [7:0]  Count = 8'd0;
  logic [15:0] rate16;
  logic [7:0]  rate8;
  logic        valid16, valid8, ovr16, ovr8;

  int total = 0;
  int bad = 0;

  encoder_rate_meter #(.CW(8), .RW(16), .GATE_CYCLES(GATE)) dut16 (
    .CLK(CLK), .RST(RST), .En(En), .Clear(Clear), .Count(Count),
    .Rate(rate16), .Rate_Valid(valid16), .Rate_Ack(Rate_Ack), .Overrun(ovr16)
  );

  encoder_rate_meter #(.CW(8), .RW(8), .GATE_CYCLES(GATE)) dut8 (
    .CLK(CLK), .RST(RST), .En(En), .Clear(Clear), .Count(Count),
    .Rate(rate8), .Rate_Valid(valid8), .Rate_Ack(Rate_Ack), .Overrun(ovr8)
  );

  always #5 CLK = ~CLK;

  // Reference model: running sum of signed count steps over GATE run clocks.
  int          mSum, mTick;
  bit          mRun, mPrime, mValid, mOvr;
  logic [7:0]  mLast;
  logic [15:0] mRate16;
  logic [7:0]  mRate8;

  function automatic int satTo(input int v, input int rw);
    int hi = (1 << (rw - 1)) - 1;
    int lo = -(1 << (rw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic modelReset();
    mSum = 0; mTick = 0; mRun = 0; mPrime = 0; mValid = 0; mOvr = 0;
    mLast = 8'd0; mRate16 = 16'd0; mRate8 = 8'd0;
  endtask

  task automatic modelEdge(input logic en, input logic clr, input logic ack, input logic [7:0] cnt);
    logic [7:0] step;
    int d;
    if (clr) begin
      mRate16 = 16'd0; mRate8 = 8'd0; mValid = 0; mOvr = 0;
      mSum = 0; mTick = 0; mRun = 0; mPrime = en;
    end else if (mRun && en) begin
      step = cnt - mLast;
      d = (step >= 8'd128) ? int'(step) - 256 : int'(step);
      mSum = mSum + d;
      mLast = cnt;
      mTick = mTick + 1;
      if (mTick == GATE) begin
        if (mValid && !ack) mOvr = 1;
        mValid = 1;
        mRate16 = 16'(satTo(mSum, 16));
        mRate8 = 8'(satTo(mSum, 8));
        mSum = 0;
        mTick = 0;
      end else if (mValid && ack) begin
        mValid = 0;
      end
    end else begin
      if (mValid && ack) mValid = 0;
      if (mRun) begin
        mRun = 0; mSum = 0; mTick = 0;
      end else if (mPrime) begin
        mPrime = 0; mRun = 1; mLast = cnt; mSum = 0; mTick = 0;
      end else if (en) begin
        mPrime = 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic [15:0] e16, input logic [7:0] e8,
                             input logic eValid, input logic eOvr);
    check({name, ".rate16"}, 32'(rate16), 32'(e16));
    check({name, ".rate8"}, 32'(rate8), 32'(e8));
    check({name, ".valid16"}, 32'(valid16), 32'(eValid));
    check({name, ".valid8"}, 32'(valid8), 32'(eValid));
    check({name, ".ovr16"}, 32'(ovr16), 32'(eOvr));
    check({name, ".ovr8"}, 32'(ovr8), 32'(eOvr));
  endtask

  // Cycle-by-cycle comparison of both meters against the model.
  initial begin
    forever begin
      @(posedge CLK);
      if (RST) modelReset();
      else modelEdge(En, Clear, Rate_Ack, Count);
      #2;
      checkOutput("model", mRate16, mRate8, mValid, mOvr);
    end
  end

  // Each call consumes n rising edges, stepping Count before every edge.
  task automatic runCycles(input int n, input int step);
    repeat (n) begin
      Count = Count + 8'(step);
      @(negedge CLK);
    end
  endtask

  typedef struct {
    string       name;
    int          start;
    int          step;
    int          period;
    int          windows;
    logic [15:0] exp16;
    logic [7:0]  exp8;
  } vec_t;

  vec_t vecs[6];

  task automatic applyStimulus(input vec_t v);
    En = 1'b1; Clear = 1'b1; Rate_Ack = 1'b1; Count = 8'(v.start);
    @(negedge CLK);
    Clear = 1'b0;
    for (int k = 1; k <= GATE * v.windows + 1; k++) begin
      Count = 8'(v.start + v.step * (k / v.period));
      @(negedge CLK);
      if (k == GATE) check({v.name, ".early"}, 32'(valid16), 32'd0);
      if (k > GATE && (k % GATE) == 1) checkOutput(v.name, v.exp16, v.exp8, 1'b1, 1'b0);
    end
    Rate_Ack = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"slow_up", 0, 1, 10, 3, 16'd10, 8'd10};
    vecs[1] = '{"wrap_up", 250, 1, 1, 1, 16'd100, 8'd100};
    vecs[2] = '{"wrap_down", 3, -1, 20, 2, 16'hFFFB, 8'hFB};
    vecs[3] = '{"sat_pos", 0, 2, 1, 1, 16'd200, 8'h7F};
    vecs[4] = '{"sat_neg", 128, -2, 1, 1, 16'hFF38, 8'h80};
    vecs[5] = '{"still", 77, 0, 1, 1, 16'd0, 8'd0};

    repeat (10) @(negedge CLK);
    RST = 1'b0;
    checkOutput("reset", 16'd0, 8'd0, 1'b0, 1'b0);

    // First result appears 101 edges after En is first sampled.
    En = 1'b1;
    runCycles(GATE + 1, 1);
    check("latency.before", 32'(valid16), 32'd0);
    runCycles(1, 1);
    checkOutput("latency.first", 16'd100, 8'd100, 1'b1, 1'b0);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Missed ack, ack on the window-end edge, then overrun.
    Rate_Ack = 1'b0; Clear = 1'b1;
    @(negedge CLK);
    Clear = 1'b0;
    runCycles(GATE + 1, 1);
    checkOutput("ovr.win1", 16'd100, 8'd100, 1'b1, 1'b0);
    runCycles(GATE - 1, 2);
    Rate_Ack = 1'b1;
    runCycles(1, 2);
    Rate_Ack = 1'b0;
    checkOutput("ovr.ackAtEnd", 16'd200, 8'h7F, 1'b1, 1'b0);
    runCycles(GATE, 1);
    checkOutput("ovr.win3", 16'd100, 8'd100, 1'b1, 1'b1);
    Rate_Ack = 1'b1;
    runCycles(1, 1);
    Rate_Ack = 1'b0;
    checkOutput("ovr.acked", 16'd100, 8'd100, 1'b0, 1'b1);

    // Asynchronous reset halfway into a window.
    runCycles(GATE - 1, 1);
    checkOutput("rst.pre", 16'd100, 8'd100, 1'b1, 1'b1);
    runCycles(50, 1);
    #2 RST = 1'b1;
    #1 checkOutput("rst.async", 16'd0, 8'd0, 1'b0, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    runCycles(GATE + 1, 1);
    check("rst.relatency", 32'(valid16), 32'd0);
    runCycles(1, 1);
    checkOutput("rst.first", 16'd100, 8'd100, 1'b1, 1'b0);

    // Dropping En mid-window discards it and keeps the held result.
    runCycles(50, 1);
    En = 1'b0;
    runCycles(150, 1);
    checkOutput("en.drop", 16'd100, 8'd100, 1'b1, 1'b0);
    Clear = 1'b1;
    @(negedge CLK);
    Clear = 1'b0;
    checkOutput("clear", 16'd0, 8'd0, 1'b0, 1'b0);

    // Randomized traffic, checked against the model every clock.
    En = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) En = ~En;
      Clear = ($urandom_range(699) == 0);
      Rate_Ack = ($urandom_range(3) == 0);
      Count = Count + 8'($urandom_range(4)) - 8'd2;
      @(negedge CLK);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/encoder_rate_meter.md
Name: encoder_rate_meter

Overview:
- Downstream consumer of the 8-bit pulse counter's Count output.
- Every GATE_CYCLES clocks, measures the net change of Count and reports it as a signed rate (pulses per gate window).
- Handles 8-bit wrap-around. Result is held under a valid/ack handshake for the next stage (display or control logic).

Parameters:
- CW, 8, width of the incoming Count bus.
- RW, 16, width of the signed Rate output.
- GATE_CYCLES, 10000, clocks per measurement window (100 us at 100 MHz); must be at least 2.

Ports:
- CLK  in  1  system clock, rising-edge.
- RST  in  1  asynchronous, active-high reset.
- En  in  1  measurement enable, level.
- Clear  in  1  synchronous restart; clears the window and status.
- Count  in  CW  pulse count from the encoder counter, same clock domain.
- Rate  out  RW  signed pulses in the last completed window.
- Rate_Valid  out  1  Rate holds an unacknowledged result.
- Rate_Ack  in  1  consumer has taken Rate.
- Overrun  out  1  sticky: a result was overwritten before it was acknowledged.

Behaviour:
- Reset (RST=1, asynchronous): state=IDLE; Rate=0, Rate_Valid=0, Overrun=0; internal accumulator, gate counter and prev register all 0.
- States:
  - IDLE -> PRIME when En=1.
  - PRIME -> RUN unconditionally.
  - RUN -> IDLE when En=0.
- PRIME (one cycle): prev<=Count; acc<=0; gate<=0. No delta is accumulated.
- RUN, every cycle:
  - delta = signed CW-bit value of (Count - prev) mod 2^CW; valid while Count moves by less than 2^(CW-1) per clock.
  - acc<=acc+delta, sign-extended to RW+1 bits; prev<=Count; gate<=gate+1.
- Window end (RUN and gate==GATE_CYCLES-1):
  - Rate<=saturate(acc+delta) to the signed RW range, clamped to [-2^(RW-1), 2^(RW-1)-1].
  - acc<=0; gate<=0; Rate_Valid<=1.
  - Stay in RUN, so windows are back-to-back with no dead cycle.
  - First result appears GATE_CYCLES+1 clocks after the En=1 edge is sampled (1 PRIME + GATE_CYCLES RUN).
- Handshake:
  - Rate_Valid=1 and Rate_Ack=1 -> Rate_Valid<=0 next edge.
  - Rate_Ack while Rate_Valid=0 is ignored.
  - Rate is stable while Rate_Valid=1, except when overwritten by a new window end.
- Simultaneous window end and Ack: the new result wins; Rate_Valid stays 1; no overrun.
- Window end while Rate_Valid=1 and Rate_Ack=0: Rate is overwritten and Overrun<=1. Overrun is sticky until Clear or RST.
- En=0 during RUN: next state IDLE; partial window discarded (acc, gate cleared); Rate and Rate_Valid hold.
- Clear=1 (priority over all except RST):
  - acc, gate, Rate, Rate_Valid, Overrun <= 0.
  - Next state is PRIME if En=1, else IDLE.
- Upstream counter reset mid-window: Count jumping to 0 appears as one large delta. Consumers must pulse Clear together with the counter reset.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package: state encoding constants (IDLE, PRIME, RUN); the CW/RW defaults; the saturation limits as functions of RW.
- One natural sub-module: rate_sat_acc, the signed accumulator with saturating output conversion.
- The FSM, gate counter and handshake remain in the top level.

Test Plan:
- Bench uses GATE_CYCLES=100.
- Scenario 1: RST for 10 clocks, then En=1; Count +1 every 10 clocks -> Rate_Valid rises 101 clocks after En is sampled; Rate=10; Ack each result -> Rate=10 every 100 clocks, Overrun=0.
- Scenario 2: Count starts at 250 and increments by 1 every clock through 255->0 -> Rate=100; no wrap error.
- Scenario 3: Count decrements by 1 every 20 clocks starting at 3, wrapping to 255 -> Rate=-5 (0xFFFB at RW=16).
- Scenario 4: RW=8, Count +2 every clock -> Rate saturates at 127 (0x7F).
- Scenario 5: no Ack for two windows -> Overrun=1 at the second window end and Rate is updated; Ack on the exact window-end cycle -> Rate_Valid stays 1, Overrun unchanged.
- Scenario 6, mid-window events:
  - RST at clock 50 of a window -> all outputs 0 immediately (asynchronous).
  - After RST release, the next result needs a full PRIME+100 clocks.
  - En=0 mid-window -> no result; previous Rate and Rate_Valid retained.
  - Clear -> Rate=0, Rate_Valid=0, Overrun=0.
